// File: rtl/lcd_init_seq.sv
// lcd_init_seq: reads the LCD init ROM word by word and shifts each {DCX,DATA} out on the 4-wire SPI bus.
// Define LCD_HWRESET_EN to add an lcd_rstn pulse and settle wait before the first word.
module lcd_init_seq #(
  parameter int CLK_DIV     = 2,
  parameter int LAST_ADDR   = 103,
  parameter int SLPOUT_WAIT = 6000000,
  parameter int RST_LOW     = 500000,
  parameter int RST_WAIT    = 6000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [6:0] rom_addr,
  input  logic [8:0] rom_data,
  output logic       lcd_csx,
  output logic       lcd_dcx,
  output logic       lcd_scl,
  output logic       lcd_sda,
  output logic       lcd_rstn,
  output logic       busy,
  output logic       done
);

  localparam int              DIV_W       = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LD     = DIV_W'(CLK_DIV - 1);
  localparam logic [6:0]      LAST        = 7'(LAST_ADDR);
  localparam logic [31:0]     SLP_LD      = 32'(SLPOUT_WAIT);
  localparam logic [8:0]      SLPOUT_WORD = {1'b0, 8'h11};
`ifdef LCD_HWRESET_EN
  localparam logic [31:0]     RST_LOW_LD  = 32'(RST_LOW - 1);
  localparam logic [31:0]     RST_WAIT_LD = 32'(RST_WAIT - 1);
`endif

  if (CLK_DIV < 1 || LAST_ADDR < 0 || LAST_ADDR > 127 || RST_LOW < 1 || RST_WAIT < 1 ||
      SLPOUT_WAIT < 0) begin : g_param_check
    $error("lcd_init_seq: parameter out of range");
  end

  typedef enum logic [3:0] {
`ifdef LCD_HWRESET_EN
    HW_LOW,
    HW_WAIT,
`endif
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    GAP,
    DELAY,
    FIN
  } state_t;

  state_t           state, state_nxt;
  logic [6:0]       rom_addr_nxt;
  logic             csx_nxt, dcx_nxt, scl_nxt, sda_nxt, rstn_nxt, busy_nxt, done_nxt;
  logic [6:0]       shreg, shreg_nxt;
  logic             slpout, slpout_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [31:0]      dly_cnt, dly_cnt_nxt;
  logic             advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      lcd_csx  <= 1'b1;
      lcd_dcx  <= 1'b0;
      lcd_scl  <= 1'b0;
      lcd_sda  <= 1'b0;
      lcd_rstn <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      shreg    <= '0;
      slpout   <= 1'b0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      dly_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      rom_addr <= rom_addr_nxt;
      lcd_csx  <= csx_nxt;
      lcd_dcx  <= dcx_nxt;
      lcd_scl  <= scl_nxt;
      lcd_sda  <= sda_nxt;
      lcd_rstn <= rstn_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      shreg    <= shreg_nxt;
      slpout   <= slpout_nxt;
      bit_cnt  <= bit_cnt_nxt;
      div_cnt  <= div_cnt_nxt;
      dly_cnt  <= dly_cnt_nxt;
    end
  end

  // SHIFT uses lcd_scl itself as the half-period phase; SDA moves on the SCL falling edge.
  always_comb begin
    state_nxt    = state;
    rom_addr_nxt = rom_addr;
    csx_nxt      = lcd_csx;
    dcx_nxt      = lcd_dcx;
    scl_nxt      = lcd_scl;
    sda_nxt      = lcd_sda;
    rstn_nxt     = lcd_rstn;
    busy_nxt     = busy;
    done_nxt     = done;
    shreg_nxt    = shreg;
    slpout_nxt   = slpout;
    bit_cnt_nxt  = bit_cnt;
    div_cnt_nxt  = div_cnt;
    dly_cnt_nxt  = dly_cnt;
    advance      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          busy_nxt     = 1'b1;
          done_nxt     = 1'b0;
          rom_addr_nxt = '0;
`ifdef LCD_HWRESET_EN
          rstn_nxt     = 1'b0;
          dly_cnt_nxt  = RST_LOW_LD;
          state_nxt    = HW_LOW;
`else
          state_nxt    = FETCH;
`endif
        end
      end
`ifdef LCD_HWRESET_EN
      HW_LOW: begin
        if (dly_cnt == '0) begin
          rstn_nxt    = 1'b1;
          dly_cnt_nxt = RST_WAIT_LD;
          state_nxt   = HW_WAIT;
        end else begin
          dly_cnt_nxt = dly_cnt - 32'd1;
        end
      end
      HW_WAIT: begin
        if (dly_cnt == '0) state_nxt = FETCH;
        else               dly_cnt_nxt = dly_cnt - 32'd1;
      end
`endif
      FETCH: state_nxt = LOAD;
      LOAD: begin
        shreg_nxt   = rom_data[6:0];
        sda_nxt     = rom_data[7];
        dcx_nxt     = rom_data[8];
        slpout_nxt  = (rom_data == SLPOUT_WORD);
        csx_nxt     = 1'b0;
        bit_cnt_nxt = 3'd7;
        div_cnt_nxt = DIV_LD;
        state_nxt   = SHIFT;
      end
      SHIFT: begin
        if (div_cnt != '0) begin
          div_cnt_nxt = div_cnt - 1'b1;
        end else begin
          div_cnt_nxt = DIV_LD;
          if (!lcd_scl) begin
            scl_nxt = 1'b1;
          end else begin
            scl_nxt = 1'b0;
            if (bit_cnt == 3'd0) begin
              csx_nxt   = 1'b1;
              state_nxt = GAP;
            end else begin
              bit_cnt_nxt = bit_cnt - 3'd1;
              sda_nxt     = shreg[6];
              shreg_nxt   = {shreg[5:0], 1'b0};
            end
          end
        end
      end
      GAP: begin
        if (div_cnt != '0) begin
          div_cnt_nxt = div_cnt - 1'b1;
        end else if (slpout) begin
          dly_cnt_nxt = SLP_LD;
          state_nxt   = DELAY;
        end else begin
          advance = 1'b1;
        end
      end
      DELAY: begin
        if (dly_cnt == '0) advance = 1'b1;
        else               dly_cnt_nxt = dly_cnt - 32'd1;
      end
      FIN: begin
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // rom_addr stops at LAST so the ROM is never read past the table.
    if (advance) begin
      if (rom_addr == LAST) begin
        state_nxt = FIN;
      end else begin
        rom_addr_nxt = rom_addr + 7'd1;
        state_nxt    = FETCH;
      end
    end
  end

endmodule

// File: tb/tb_lcd_init_seq.sv
// Bench for lcd_init_seq: behavioural 1-clk ROM, SPI-decoding monitor and a scoreboard of expected
// words and CSX timing derived from the ROM contents.
`timescale 1ns/1ps
module tb_lcd_init_seq;

  localparam int CLK_DIV     = 2;
  localparam int LAST_ADDR   = 3;
  localparam int SLPOUT_WAIT = 20;
  localparam int RST_LOW     = 4;
  localparam int RST_WAIT    = 4;
  localparam int WORDS       = LAST_ADDR + 1;
  localparam logic [8:0] SPEC [4] = '{9'h0F9, 9'h100, 9'h011, 9'h029};

  typedef struct {
    logic [8:0] word;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [6:0] rom_addr;
  logic [8:0] rom_data = '0;
  logic       lcd_csx, lcd_dcx, lcd_scl, lcd_sda, lcd_rstn, busy, done;

  logic [8:0] rom [0:127];
  exp_t       exp_q[$];
  exp_t       mon_e;
  int         tests = 0;
  int         fails = 0;
  int         words_seen = 0;
  int         run_words = 0;
  int         rstn_low = 0;
  bit         addr_bad = 0, sda_bad = 0, scl_bad = 0;

  lcd_init_seq #(
    .CLK_DIV(CLK_DIV), .LAST_ADDR(LAST_ADDR), .SLPOUT_WAIT(SLPOUT_WAIT),
    .RST_LOW(RST_LOW), .RST_WAIT(RST_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .lcd_csx(lcd_csx), .lcd_dcx(lcd_dcx), .lcd_scl(lcd_scl), .lcd_sda(lcd_sda),
    .lcd_rstn(lcd_rstn), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: decodes the SPI bus on the falling clk edge and pops the scoreboard at each CSX rise.
  logic       prev_csx = 1'b1, prev_scl = 1'b0, prev_sda = 1'b0, prev_done = 1'b0, prev_rstn = 1'b1;
  logic       dcx0 = 1'b0;
  logic [7:0] rx = '0;
  int         nbits = 0, low_cnt = 0, high_cnt = 0, pend_gap = 0, rel_cnt = 0;
  bit         dcx_ok = 1, released = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_csx  = 1'b1;
      prev_scl  = 1'b0;
      prev_sda  = 1'b0;
      prev_done = 1'b0;
      prev_rstn = 1'b1;
      nbits     = 0;
      pend_gap  = 0;
      high_cnt  = 0;
      released  = 0;
    end else begin
      if (rom_addr > 7'(LAST_ADDR)) addr_bad = 1;
      if (lcd_csx && lcd_scl) scl_bad = 1;
      if (lcd_scl && (lcd_sda !== prev_sda)) sda_bad = 1;
      if (!lcd_rstn) rstn_low++;
      if (lcd_rstn && !prev_rstn) begin
        released = 1;
        rel_cnt  = 0;
      end
      if (released) rel_cnt++;
      if (done && !prev_done) begin
        if (pend_gap > 0) checkOutput("done_latency", 32'(high_cnt), 32'(pend_gap - 1));
        checkOutput("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
        pend_gap = 0;
      end
      if (!lcd_csx) begin
        if (prev_csx) begin
          if (pend_gap > 0) checkOutput("csx_gap", 32'(high_cnt), 32'(pend_gap));
          if (released) begin
            checkOutput("rstn_release_to_csx", 32'(rel_cnt >= RST_WAIT), 32'd1);
            released = 0;
          end
          pend_gap = 0;
          nbits    = 0;
          low_cnt  = 0;
          dcx0     = lcd_dcx;
          dcx_ok   = 1;
        end
        low_cnt++;
        if (lcd_scl && !prev_scl) begin
          rx = {rx[6:0], lcd_sda};
          nbits++;
          if (lcd_dcx !== dcx0) dcx_ok = 0;
        end
      end else begin
        if (!prev_csx) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_word", {23'd0, dcx0, rx}, 32'h1FF_FFFF);
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput("word", {23'd0, dcx0, rx}, {23'd0, mon_e.word});
            checkOutput("scl_rises", 32'(nbits), 32'd8);
            checkOutput("csx_low_len", 32'(low_cnt), 32'(16 * CLK_DIV));
            checkOutput("dcx_stable", 32'(dcx_ok), 32'd1);
            pend_gap = mon_e.gap;
          end
          words_seen++;
          high_cnt = 0;
        end
        high_cnt++;
      end
      prev_csx  = lcd_csx;
      prev_scl  = lcd_scl;
      prev_sda  = lcd_sda;
      prev_done = done;
      prev_rstn = lcd_rstn;
    end
  end

  // Loads the ROM, queues the expected words with the CSX-high time that must follow each one,
  // then pulses start.
  task automatic applyStimulus(input bit spec_words);
    logic [8:0] w;
    int         g;
    for (int a = 0; a < WORDS; a++) begin
      if (spec_words)                 w = SPEC[a];
      else if ($urandom_range(0, 3) == 0) w = 9'h011;
      else                            w = 9'($urandom);
      rom[a] = w;
      g = CLK_DIV + 2;
      if (w == 9'h011) g = g + SLPOUT_WAIT + 1;
      exp_q.push_back('{word: w, gap: g});
    end
    run_words = words_seen;
    rstn_low  = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("done_cleared", 32'(done), 32'd0);
    checkOutput("rom_addr_after_start", 32'(rom_addr), 32'd0);
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", 32'(done), 32'd1);
    checkOutput("busy_at_done", 32'(busy), 32'd0);
    checkOutput("word_count", 32'(words_seen - run_words), 32'(WORDS));
    checkOutput("rom_addr_at_done", 32'(rom_addr), 32'(LAST_ADDR));
`ifdef LCD_HWRESET_EN
    checkOutput("rstn_low_len", 32'(rstn_low), 32'(RST_LOW));
`else
    checkOutput("rstn_low_len", 32'(rstn_low), 32'd0);
`endif
  endtask

  initial begin
    int n;
    for (int a = 0; a < 128; a++) rom[a] = 9'h1FF;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("reset_csx", 32'(lcd_csx), 32'd1);
    checkOutput("reset_dcx", 32'(lcd_dcx), 32'd0);
    checkOutput("reset_scl", 32'(lcd_scl), 32'd0);
    checkOutput("reset_sda", 32'(lcd_sda), 32'd0);
    checkOutput("reset_rstn", 32'(lcd_rstn), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Specification ROM, with extra start pulses while busy that must be ignored.
    applyStimulus(1'b1);
    for (int p = 0; p < 3; p++) begin
      repeat ($urandom_range(5, 40)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_hold_on_start", 32'(busy), 32'd1);
    end
    waitDone(2000);
    repeat ($urandom_range(3, 10)) @(negedge clk);
    checkOutput("done_sticky", 32'(done), 32'd1);
    checkOutput("busy_stays_low", 32'(busy), 32'd0);

    // Reset in the middle of shifting word 1.
    applyStimulus(1'b1);
    n = 0;
    while (!((words_seen - run_words) >= 1 && !lcd_csx) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_word1", 32'(n < 500), 32'd1);
    repeat ($urandom_range(2, 24)) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checkOutput("abort_csx", 32'(lcd_csx), 32'd1);
    checkOutput("abort_scl", 32'(lcd_scl), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_rom_addr", 32'(rom_addr), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Random ROM contents, SLPOUT words appearing at random positions.
    for (int r = 0; r < 4; r++) begin
      applyStimulus(1'b0);
      waitDone(2000);
      repeat ($urandom_range(1, 6)) @(negedge clk);
    end

    checkOutput("rom_addr_in_range", 32'(addr_bad), 32'd0);
    checkOutput("sda_stable_while_scl_high", 32'(sda_bad), 32'd0);
    checkOutput("scl_low_while_csx_high", 32'(scl_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
